// File: rtl/util_adc_timestamp_insert_pkg.sv
// Shared types and default widths for the ADC timestamp inserter.
package util_adc_timestamp_insert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH      = 64;
    localparam int DEFAULT_TIMESTAMP_WIDTH = 64;
    localparam int EVERY_WIDTH             = 32;

endpackage

// File: rtl/util_adc_timestamp_insert.sv
// ADC receive-path timestamp inserter: emits one zero-extended timestamp
// word ahead of every timestamp_every-th packed record on the way to the
// RX DMA. Optional build macro UTIL_ADC_TIMESTAMP_INSERT_DROP_EN makes the
// block never stall the ADC; records that cannot be stored are dropped,
// flagged on overflow, and the next stored record opens a new block.
// DATA_WIDTH must be at least TIMESTAMP_WIDTH.
module util_adc_timestamp_insert
    import util_adc_timestamp_insert_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int TIMESTAMP_WIDTH = DEFAULT_TIMESTAMP_WIDTH
) (
    input  logic                       adc_clk,
    input  logic                       resetn,
    input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
    input  logic [EVERY_WIDTH-1:0]     timestamp_every,
    input  logic                       xfer_req,
    input  logic                       s_axis_valid,
    output logic                       s_axis_ready,
    input  logic [DATA_WIDTH-1:0]      s_axis_data,
    output logic                       m_axis_valid,
    input  logic                       m_axis_ready,
    output logic [DATA_WIDTH-1:0]      m_axis_data,
    output logic                       overflow
);

    state_t                 state;
    state_t                 state_d;
    logic                   drain_q;
    logic [EVERY_WIDTH-1:0] ts_every_q;
    logic [EVERY_WIDTH-1:0] rec_cnt;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  ts_ext;

    logic                   out_fire;
    logic                   out_free;
    logic                   stopping;
    logic                   block_first;
    logic                   ready_int;
    logic                   store;
`ifdef UTIL_ADC_TIMESTAMP_INSERT_DROP_EN
    logic                   drop;
    logic                   overflow_q;
`endif

    assign ts_ext      = DATA_WIDTH'(timestamp);
    assign out_fire    = out_valid && m_axis_ready;
    // The output register is free this cycle if it is empty or being emptied.
    assign out_free    = !out_valid || m_axis_ready;
    // Once xfer_req has fallen we only drain, even if it rises again early.
    assign stopping    = drain_q || !xfer_req;
    assign block_first = (ts_every_q != '0) && (rec_cnt == '0);

    assign s_axis_ready = resetn && ready_int;
    assign m_axis_valid = out_valid;
    assign m_axis_data  = out_data;

    // Next-state and input-acceptance decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state;
        ready_int = 1'b0;
        store     = 1'b0;
`ifdef UTIL_ADC_TIMESTAMP_INSERT_DROP_EN
        drop      = 1'b0;
`endif
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (xfer_req) state_d = RUN;
            end
            RUN: begin
                if (!stopping) begin
`ifdef UTIL_ADC_TIMESTAMP_INSERT_DROP_EN
                    ready_int = 1'b1;
                    drop      = s_axis_valid && !out_free;
`else
                    ready_int = out_free;
`endif
                    store = s_axis_valid && out_free;
                    if (store && block_first) state_d = HOLD;
                end else if (out_free) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
`ifdef UTIL_ADC_TIMESTAMP_INSERT_DROP_EN
                ready_int = !stopping;
                drop      = s_axis_valid && !stopping;
`endif
                if (out_fire) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge adc_clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register in the design samples pre-edge values.
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    // Transfer bookkeeping: block size snapshot, drain flag, record counter.
    always_ff @(posedge adc_clk or negedge resetn) begin
        if (!resetn) begin
            ts_every_q <= '0;
            drain_q    <= 1'b0;
            rec_cnt    <= '0;
        end else begin
            if (state == IDLE && xfer_req) ts_every_q <= timestamp_every;

            if (state_d == IDLE)                  drain_q <= 1'b0;
            else if (state != IDLE && !xfer_req)  drain_q <= 1'b1;

            if (state == IDLE) begin
                rec_cnt <= '0;
            end else if (store && ts_every_q != '0) begin
                rec_cnt <= (rec_cnt + 1'b1 == ts_every_q) ? '0 : rec_cnt + 1'b1;
`ifdef UTIL_ADC_TIMESTAMP_INSERT_DROP_EN
            end else if (drop) begin
                rec_cnt <= '0;
`endif
            end
        end
    end

    // Output stage and hold register: timestamp goes out first, record waits.
    always_ff @(posedge adc_clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            hold_data <= '0;
        end else if (store) begin
            out_valid <= 1'b1;
            if (block_first) begin
                out_data  <= ts_ext;
                hold_data <= s_axis_data;
            end else begin
                out_data  <= s_axis_data;
            end
        end else if (state == HOLD && out_fire) begin
            out_data <= hold_data;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef UTIL_ADC_TIMESTAMP_INSERT_DROP_EN
    // One overflow pulse per dropped record.
    always_ff @(posedge adc_clk or negedge resetn) begin
        if (!resetn) overflow_q <= 1'b0;
        else         overflow_q <= drop;
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_util_adc_timestamp_insert.sv
// Self-checking bench for util_adc_timestamp_insert: a scoreboard queue of
// expected output beats plus a per-cycle vector table for the plain path.
module tb_util_adc_timestamp_insert;

    logic        adc_clk = 1'b0;
    logic        resetn;
    logic [63:0] timestamp;
    logic [31:0] timestamp_every;
    logic        xfer_req;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic [63:0] s_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic [63:0] m_axis_data;
    logic        overflow;

    util_adc_timestamp_insert #(
        .DATA_WIDTH      (64),
        .TIMESTAMP_WIDTH (64)
    ) dut (
        .adc_clk         (adc_clk),
        .resetn          (resetn),
        .timestamp       (timestamp),
        .timestamp_every (timestamp_every),
        .xfer_req        (xfer_req),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .s_axis_data     (s_axis_data),
        .m_axis_valid    (m_axis_valid),
        .m_axis_ready    (m_axis_ready),
        .m_axis_data     (m_axis_data),
        .overflow        (overflow)
    );

    always #5 adc_clk = ~adc_clk;

    // Free-running sample counter; ts_off lets a test pick its start value.
    logic [63:0] cyc = 64'd0;
    logic [63:0] ts_off = 64'd0;
    always @(posedge adc_clk) cyc <= cyc + 64'd1;
    assign timestamp = cyc + ts_off;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        exp_rdy;
        logic        exp_mv;
        logic [63:0] exp_md;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mdl_every = 32'd0;
    logic [31:0] mdl_cnt = 32'd0;
    bit          push_en = 1'b1;
    logic [3:0]  rdy_pat = 4'b1111;
    int          pat_idx = 0;
    logic        xfer_nxt = 1'b0;
    logic [31:0] every_nxt = 32'd0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = 64'd0;
    int          ovf_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output-side checks, evaluated mid-cycle while everything is stable.
    task automatic monitor();
        if (overflow) ovf_seen++;
        if (prev_stall && m_axis_valid) check("stable_while_stalled", m_axis_data, prev_data);
        if (m_axis_valid && m_axis_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 64'(m_axis_valid), 64'd0);
            else                   check("beat", m_axis_data, exp_q.pop_front());
        end
        prev_stall = m_axis_valid && !m_axis_ready;
        prev_data  = m_axis_data;
    endtask

    // One clock: drive after the rising edge, observe on the falling edge.
    task automatic cycle(input logic v, input logic [63:0] d, output logic acc);
        @(posedge adc_clk);
        #1;
        s_axis_valid    = v;
        s_axis_data     = d;
        xfer_req        = xfer_nxt;
        timestamp_every = every_nxt;
        m_axis_ready    = rdy_pat[pat_idx % 4];
        pat_idx++;
        @(negedge adc_clk);
        monitor();
        acc = v && s_axis_ready;
        if (acc && push_en) begin
            if (mdl_every != 0 && mdl_cnt == 0) exp_q.push_back(timestamp);
            exp_q.push_back(d);
            if (mdl_every != 0) mdl_cnt = (mdl_cnt + 1 == mdl_every) ? 32'd0 : mdl_cnt + 1;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, acc);
    endtask

    task automatic send(input int n, input logic [63:0] base);
        logic acc;
        for (int i = 0; i < n; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) cycle(1'b1, base + 64'(i), acc);
            if (!acc) check("send_accept", 64'(acc), 64'd1);
        end
    endtask

    task automatic start(input logic [31:0] every);
        xfer_nxt  = 1'b1;
        every_nxt = every;
        mdl_every = every;
        mdl_cnt   = 32'd0;
        idle(2);
    endtask

    task automatic drain(input string name);
        logic acc;
        for (int t = 0; t < 100 && (exp_q.size() != 0 || m_axis_valid); t++) cycle(1'b0, 64'd0, acc);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic stop_and_drain(input string name);
        xfer_nxt = 1'b0;
        drain(name);
        idle(2);
        check({name, "_idle_ready"}, 64'(s_axis_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        logic acc;
        int   ovf0;

        resetn = 1'b0;
        xfer_req = 1'b0;
        timestamp_every = 32'd0;
        s_axis_valid = 1'b0;
        s_axis_data = 64'd0;
        m_axis_ready = 1'b1;
        idle(3);
        check("reset_s_ready", 64'(s_axis_ready), 64'd0);
        check("reset_m_valid", 64'(m_axis_valid), 64'd0);
        check("reset_m_data",  m_axis_data,       64'd0);
        check("reset_overflow", 64'(overflow),    64'd0);
        resetn = 1'b1;
        idle(1);
        check("idle_s_ready", 64'(s_axis_ready), 64'd1);

        // Insertion disabled: one-stage register, per-cycle table.
        for (int k = 0; k < 13; k++) begin
            tbl[k].v       = (k < 12);
            tbl[k].d       = (k < 12) ? 64'(k + 1) : 64'd0;
            tbl[k].exp_rdy = 1'b1;
            tbl[k].exp_mv  = (k > 0);
            tbl[k].exp_md  = 64'(k);
        end
        rdy_pat = 4'b1111;
        start(32'd0);
        for (int k = 0; k < 13; k++) begin
            cycle(tbl[k].v, tbl[k].d, acc);
            check("t1_s_ready", 64'(s_axis_ready), 64'(tbl[k].exp_rdy));
            check("t1_m_valid", 64'(m_axis_valid), 64'(tbl[k].exp_mv));
            if (tbl[k].exp_mv) check("t1_m_data", m_axis_data, tbl[k].exp_md);
        end
        stop_and_drain("t1_drain");

        // Blocks of 4 with timestamp counting from 100.
        ts_off = 64'd100 - cyc;
        start(32'd4);
        send(12, 64'h200);
        stop_and_drain("t2_drain");

        // Change of timestamp_every mid-transfer is ignored.
        start(32'd4);
        send(2, 64'h500);
        every_nxt = 32'd2;
        send(6, 64'h510);
        stop_and_drain("t5_drain");

`ifndef UTIL_ADC_TIMESTAMP_INSERT_DROP_EN
        // Downstream ready toggling 1,0,0,1.
        rdy_pat = 4'b1001;
        start(32'd3);
        send(10, 64'h300);
        rdy_pat = 4'b1111;
        stop_and_drain("t3_drain");

        // xfer_req falls while the held record waits behind its timestamp.
        rdy_pat = 4'b0000;
        start(32'd4);
        send(1, 64'h400);
        xfer_nxt = 1'b0;
        idle(2);
        rdy_pat = 4'b1111;
        stop_and_drain("t4_drain");
        start(32'd4);
        send(2, 64'h410);
        stop_and_drain("t4_restart_drain");
        check("no_overflow", 64'(ovf_seen), 64'd0);
`else
        // Drop build: stalled downstream for 5 cycles with valid held high.
        start(32'd4);
        push_en = 1'b0;
        rdy_pat = 4'b0000;
        ovf0 = ovf_seen;
        cycle(1'b1, 64'h600, acc);
        exp_q.push_back(timestamp);
        exp_q.push_back(64'h600);
        for (int i = 1; i < 5; i++) cycle(1'b1, 64'h600 + 64'(i), acc);
        rdy_pat = 4'b1111;
        idle(1);
        cycle(1'b1, 64'h605, acc);
        check("t6_accept", 64'(acc), 64'd1);
        exp_q.push_back(timestamp);
        exp_q.push_back(64'h605);
        idle(2);
        check("t6_overflow_pulses", 64'(ovf_seen - ovf0), 64'd4);
        push_en = 1'b1;
        stop_and_drain("t6_drain");
`endif

        // Reset asserted while a beat is pending clears everything at once.
        rdy_pat = 4'b0000;
        start(32'd0);
        send(1, 64'h700);
        resetn = 1'b0;
        #1;
        check("t7_rst_m_valid", 64'(m_axis_valid), 64'd0);
        check("t7_rst_m_data",  m_axis_data,       64'd0);
        check("t7_rst_s_ready", 64'(s_axis_ready), 64'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        xfer_nxt = 1'b0;
        rdy_pat = 4'b1111;
        idle(1);
        resetn = 1'b1;
        idle(2);
        check("t7_idle_ready", 64'(s_axis_ready), 64'd1);
        check("t7_idle_valid", 64'(m_axis_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/util_adc_timestamp_insert.md
# util_adc_timestamp_insert

Receive-path counterpart of the transmit timestamp unpacker. Sits between the ADC channel packer and the RX DMA, in the ADC clock domain. It inserts a one-beat timestamp word ahead of every `timestamp_every`-th packed record. The host can then recover the exact sample time of each block using the same framing it writes on the TX path.

## Interface
- `DATA_WIDTH`, 64: width of packed record and of the timestamp word; must be ≥ `TIMESTAMP_WIDTH`.
- `TIMESTAMP_WIDTH`, 64: width of the free-running `timestamp` input; zero-extended to `DATA_WIDTH` on output.
- `adc_clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `timestamp`  in  TIMESTAMP_WIDTH  free-running sample counter, `adc_clk` domain.
- `timestamp_every`  in  32  records per block; 0 = insertion disabled.
- `xfer_req`  in  1  DMA transfer active.
- `s_axis_valid`  in  1  packed record valid.
- `s_axis_ready`  out  1  record accepted when high with valid.
- `s_axis_data`  in  DATA_WIDTH  packed record.
- `m_axis_valid`  out  1  output beat valid.
- `m_axis_ready`  in  1  DMA accepts beat.
- `m_axis_data`  out  DATA_WIDTH  timestamp word or record.
- `overflow`  out  1  one-cycle pulse per dropped record; tied 0 unless the drop feature is compiled in.

## Operation
- Registered output stage (`out`) plus one hold register (`hold`).
- Record counter `rec_cnt` (32 b).
- `ts_every_q` is latched from `timestamp_every` on the `xfer_req` rising edge; mid-transfer changes are ignored.
- State IDLE:
  - `s_axis_ready`=1; input is discarded; `m_axis_valid`=0; `rec_cnt`=0.
  - On `xfer_req`=1, go to RUN.
- State RUN:
  - `s_axis_ready` = `!m_axis_valid || m_axis_ready`.
  - On acceptance with `ts_every_q`≠0 and `rec_cnt`==0:
    - `out` ← zero-extended `timestamp` sampled in the acceptance cycle.
    - `hold` ← record.
    - Go to HOLD.
  - Other acceptances: `out` ← record.
  - `rec_cnt` increments on every accepted record and wraps to 0 at `ts_every_q`.
  - With `ts_every_q`==0 the block is a pure one-stage register and `rec_cnt` stays 0.
- State HOLD:
  - `s_axis_ready`=0.
  - When the timestamp beat is accepted (`m_axis_valid && m_axis_ready`): `out` ← `hold`, go to RUN.
- `xfer_req` fall:
  - No new records are accepted.
  - Any beat in `out`/`hold` is drained in order; then go to IDLE and reset `rec_cnt`.
  - A falling edge in HOLD still emits the held record.
  - `xfer_req` rising again before the drain completes is ignored until IDLE is reached.
- Each transfer therefore begins with a timestamp word whenever insertion is enabled.

## Timing
- Reset values:
  - `m_axis_valid`=0, `m_axis_data`=0, `overflow`=0, state IDLE, `rec_cnt`=0, `hold`=0.
  - `s_axis_ready` is forced 0 while `resetn` is low.
- Latency: record accepted in cycle N appears on `m_axis` in N+1.
- A block-first record appears in N+1+k, where k is the number of cycles the timestamp beat waits for `m_axis_ready`.
- Full-rate throughput with `ts_every_q`=0 and `m_axis_ready` held high.
- With insertion enabled, the input stalls exactly one cycle per block.
- `m_axis_data` is stable while `m_axis_valid && !m_axis_ready`.
- Reset asserted mid-operation: all state clears immediately; partial blocks are lost.

## Configuration
- `UTIL_ADC_TIMESTAMP_INSERT_DROP_EN` defined:
  - `s_axis_ready`=1 in RUN and HOLD (the ADC is never stalled).
  - A record arriving when it cannot be stored is dropped and `overflow` pulses for one cycle.
  - `rec_cnt` is forced to 0, so the next stored record starts a new block with a fresh timestamp; the host sees the gap as a timestamp jump.
- Undefined: backpressure propagates as described above; `overflow` is constant 0.

## Structure
- Package `util_adc_timestamp_insert_pkg`: state enum (IDLE, RUN, HOLD) and default width constants.
- Single module; no sub-module is warranted.

## Test plan
- `timestamp_every`=0, records 1..12, `m_axis_ready`=1: output is records 1..12, each one cycle after acceptance, with no timestamp words.
- `timestamp_every`=4, 12 records, `timestamp` starting at 100 and incrementing each cycle:
  - Output is TS, r1–r4, TS, r5–r8, TS, r9–r12.
  - Each TS equals `timestamp` at the cycle its first record was accepted.
- Insertion enabled, `m_axis_ready` toggling 1,0,0,1 repeatedly: no loss or duplication; data stable while stalled; TS always immediately precedes its block.
- `xfer_req` dropped while in HOLD: held record is still emitted after TS; returns to IDLE; a new `xfer_req` starts with a TS.
- `timestamp_every` changed 4→2 mid-transfer: blocks remain 4 records until the next `xfer_req` rise.
- Drop build, `m_axis_ready`=0 for 5 cycles with `s_axis_valid`=1:
  - `overflow` pulses once per dropped record.
  - The first record stored after recovery is preceded by a fresh TS.
